// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: two-port cache line transfer controller and arbiter
// Optional round-robin arbitration: define MEM_LINE_CTRL_RR_EN.
module mem_line_ctrl #(
  parameter int ADDR_W         = 28,
  parameter int WORDS_PER_LINE = 4,
  parameter int ACCESS_LAT     = 2,
  localparam int LINE_W        = 32 * WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [LINE_W-1:0] r0_wline,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [LINE_W-1:0] r0_rline,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [LINE_W-1:0] r1_wline,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [LINE_W-1:0] r1_rline,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int LC_W  = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
  localparam logic [LC_W-1:0]   LC_LAST  = LC_W'(ACCESS_LAT - 1);
  localparam logic [OFF_W-1:0]  WC_LAST  = OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(WORDS_PER_LINE - 1);
  localparam logic              LAT1     = (ACCESS_LAT == 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e            state_q;
  logic [OFF_W-1:0]  wc_q;
  logic [LC_W-1:0]   lc_q;
  logic              we_q;
  logic              own_q;
  logic [ADDR_W-1:0] base_q;
  logic [LINE_W-1:0] wline_q;
  logic [LINE_W-1:0] line_q;
  logic              r0_gnt_q;
  logic              r1_gnt_q;
  logic              r0_done_q;
  logic              r1_done_q;
  logic [LINE_W-1:0] r0_rline_q;
  logic [LINE_W-1:0] r1_rline_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [31:0]       mem_wdata_q;
  logic              busy_q;

`ifdef MEM_LINE_CTRL_RR_EN
  logic              ptr_q;
`endif

  logic              any_req;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_base;
  logic [LINE_W-1:0] sel_wline;
  logic [OFF_W-1:0]  wc_nx;
  logic [LC_W-1:0]   lc_nx;
  logic [LINE_W-1:0] line_d;
  logic [31:0]       wword_nx;

  // Arbitration: pick the requester to serve from IDLE
  always_comb begin
    any_req = r0_req | r1_req;
`ifdef MEM_LINE_CTRL_RR_EN
    win = (r0_req & r1_req) ? ~ptr_q : r1_req;
`else
    win = ~r0_req;
`endif
    sel_we    = win ? r1_we : r0_we;
    sel_base  = (win ? r1_addr : r0_addr) & ~OFF_MASK;
    sel_wline = win ? r1_wline : r0_wline;
  end

  // Word/latency counter increments and read-line assembly
  always_comb begin
    wc_nx    = wc_q + 1'b1;
    lc_nx    = lc_q + 1'b1;
    line_d   = line_q;
    line_d[{wc_q, 5'b0} +: 32] = mem_rdata;
    wword_nx = wline_q[{wc_nx, 5'b0} +: 32];
  end

  // Transfer FSM with registered bank-port and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wc_q        <= '0;
      lc_q        <= '0;
      we_q        <= 1'b0;
      own_q       <= 1'b0;
      base_q      <= '0;
      wline_q     <= '0;
      line_q      <= '0;
      r0_gnt_q    <= 1'b0;
      r1_gnt_q    <= 1'b0;
      r0_done_q   <= 1'b0;
      r1_done_q   <= 1'b0;
      r0_rline_q  <= '0;
      r1_rline_q  <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef MEM_LINE_CTRL_RR_EN
      ptr_q       <= 1'b1;
`endif
    end else begin
      r0_gnt_q  <= 1'b0;
      r1_gnt_q  <= 1'b0;
      r0_done_q <= 1'b0;
      r1_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q     <= ACCESS;
            own_q       <= win;
            we_q        <= sel_we;
            base_q      <= sel_base;
            wline_q     <= sel_wline;
            line_q      <= '0;
            wc_q        <= '0;
            lc_q        <= '0;
            r0_gnt_q    <= ~win;
            r1_gnt_q    <= win;
            busy_q      <= 1'b1;
            mem_addr_q  <= sel_base;
            mem_we_q    <= sel_we & LAT1;
            mem_wdata_q <= sel_we ? sel_wline[31:0] : 32'd0;
`ifdef MEM_LINE_CTRL_RR_EN
            ptr_q       <= win;
`endif
          end
        end
        ACCESS: begin
          if (lc_q == LC_LAST) begin
            lc_q <= '0;
            if (!we_q) begin
              line_q <= line_d;
            end
            if (wc_q == WC_LAST) begin
              state_q     <= DONE;
              r0_done_q   <= ~own_q;
              r1_done_q   <= own_q;
              mem_addr_q  <= '0;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
              if (!we_q && !own_q) begin
                r0_rline_q <= line_d;
              end
              if (!we_q && own_q) begin
                r1_rline_q <= line_d;
              end
            end else begin
              wc_q        <= wc_nx;
              mem_addr_q  <= base_q | ADDR_W'(wc_nx);
              mem_we_q    <= we_q & LAT1;
              mem_wdata_q <= we_q ? wword_nx : 32'd0;
            end
          end else begin
            lc_q     <= lc_nx;
            mem_we_q <= we_q & (lc_nx == LC_LAST);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign r0_gnt    = r0_gnt_q;
  assign r1_gnt    = r1_gnt_q;
  assign r0_done   = r0_done_q;
  assign r1_done   = r1_done_q;
  assign r0_rline  = r0_rline_q;
  assign r1_rline  = r1_rline_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// tb_mem_line_ctrl: directed bench for mem_line_ctrl
// Second instance runs with ACCESS_LAT = 1.
module tb_mem_line_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic ld;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Cycle counter used to time every check
  always @(posedge clk) cyc <= cyc + 1;

  logic         r0_req, r0_we, r0_gnt, r0_done;
  logic [27:0]  r0_addr;
  logic [127:0] r0_wline, r0_rline;
  logic         r1_req, r1_we, r1_gnt, r1_done;
  logic [27:0]  r1_addr;
  logic [127:0] r1_wline, r1_rline;
  logic [27:0]  mem_addr;
  logic         mem_we, busy;
  logic [31:0]  mem_wdata, mem_rdata;

  logic         s_req, s_we, s_gnt, s_done;
  logic [27:0]  s_addr;
  logic [127:0] s_wline, s_rline;
  logic         u_gnt, u_done;
  logic [127:0] u_rline;
  logic [27:0]  m1_addr;
  logic         m1_we, busy1;
  logic [31:0]  m1_wdata, m1_rdata;
  logic         z_bit = 1'b0;
  logic [27:0]  z_addr = '0;
  logic [127:0] z_line = '0;

  logic [31:0] bank  [64];
  logic [31:0] bank1 [64];

  // Bank models: preload word i with (i+1)*16, then honour writes
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 64; i++) bank[i] <= 32'((i + 1) * 16);
    end else if (mem_we) begin
      bank[mem_addr[5:0]] <= mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 64; i++) bank1[i] <= 32'((i + 1) * 16);
    end else if (m1_we) begin
      bank1[m1_addr[5:0]] <= m1_wdata;
    end
  end

  assign mem_rdata = bank[mem_addr[5:0]];
  assign m1_rdata  = bank1[m1_addr[5:0]];

  mem_line_ctrl dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wline(r0_wline), .r0_gnt(r0_gnt), .r0_done(r0_done),
    .r0_rline(r0_rline),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wline(r1_wline), .r1_gnt(r1_gnt), .r1_done(r1_done),
    .r1_rline(r1_rline),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_line_ctrl #(.ACCESS_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .r0_req(s_req), .r0_we(s_we), .r0_addr(s_addr),
    .r0_wline(s_wline), .r0_gnt(s_gnt), .r0_done(s_done),
    .r0_rline(s_rline),
    .r1_req(z_bit), .r1_we(z_bit), .r1_addr(z_addr),
    .r1_wline(z_line), .r1_gnt(u_gnt), .r1_done(u_done),
    .r1_rline(u_rline),
    .mem_addr(m1_addr), .mem_we(m1_we), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .busy(busy1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // One full line transfer on the default instance, checked cycle by cycle
  task automatic xfer(input bit p, input bit we, input logic [27:0] a,
                      input logic [127:0] wl, input logic [127:0] exp_rl);
    logic         g, d;
    logic [127:0] rl;
    logic [27:0]  ea;
    int           wi;
    @(negedge clk);
    if (!p) begin
      r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wline = wl;
    end else begin
      r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wline = wl;
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      g  = p ? r1_gnt : r0_gnt;
      d  = p ? r1_done : r0_done;
      rl = p ? r1_rline : r0_rline;
      if (k == 1) begin
        r0_req = 1'b0;
        r1_req = 1'b0;
      end
      chk("gnt", 128'(g), 128'(k == 1));
      chk("done", 128'(d), 128'(k == 9));
      chk("busy", 128'(busy), 128'(k <= 9));
      if (k <= 8) begin
        wi = (k - 1) / 2;
        ea = {a[27:2], 2'(wi)};
        chk("mem_addr", 128'(mem_addr), 128'(ea));
        chk("mem_we", 128'(mem_we), 128'(we && (k % 2 == 0)));
        if (we) chk("mem_wdata", 128'(mem_wdata), 128'(wl[32*wi +: 32]));
      end else begin
        chk("addr_idle", 128'(mem_addr), 128'(0));
        chk("we_idle", 128'(mem_we), 128'(0));
      end
      if (k == 9 && !we) chk("rline", rl, exp_rl);
    end
  endtask

  logic [127:0] wl_a;
  int           ng;
  int           gk [8];
  logic         gp [8];
  logic         exp_p;

  initial begin
    rst = 1'b1; ld = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wline = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wline = '0;
    s_req = 0; s_we = 0; s_addr = '0; s_wline = '0;
    @(negedge clk);
    ld = 1'b0;
    chk("rst_gnt", 128'({r0_gnt, r1_gnt, s_gnt}), 128'(0));
    chk("rst_done", 128'({r0_done, r1_done, s_done}), 128'(0));
    chk("rst_rline0", r0_rline, 128'(0));
    chk("rst_rline1", r1_rline, 128'(0));
    chk("rst_addr", 128'(mem_addr), 128'(0));
    chk("rst_we", 128'(mem_we), 128'(0));
    chk("rst_wdata", 128'(mem_wdata), 128'(0));
    chk("rst_busy", 128'({busy, busy1}), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    xfer(1'b0, 1'b0, 28'h2, '0,
         128'h00000040_00000030_00000020_00000010);

    wl_a = {32'hD, 32'hC, 32'hB, 32'hA};
    xfer(1'b1, 1'b1, 28'h4, wl_a, '0);
    chk("bank4", 128'(bank[4]), 128'h0A);
    chk("bank7", 128'(bank[7]), 128'h0D);
    xfer(1'b1, 1'b0, 28'h4, '0, wl_a);

    @(negedge clk);
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 28'h8;
    r0_wline = {32'h44, 32'h33, 32'h22, 32'h11};
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) r0_req = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 128'(mem_we), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_addr", 128'(mem_addr), 128'(0));
    chk("mid_rst_rline", r0_rline, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("no_done", 128'({r0_done, busy}), 128'(0));
    end
    chk("bank8", 128'(bank[8]), 128'h11);
    chk("bank9", 128'(bank[9]), 128'h22);
    chk("bank10", 128'(bank[10]), 128'hB0);
    chk("bank11", 128'(bank[11]), 128'hC0);

    rst = 1'b1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = '0;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = '0;
    @(negedge clk);
    rst = 1'b0;
    ng = 0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if ((r0_gnt || r1_gnt) && ng < 8) begin
        gp[ng] = r1_gnt;
        gk[ng] = k;
        ng++;
      end
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    chk("n_gnt", 128'(ng), 128'(4));
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_LINE_CTRL_RR_EN
      exp_p = (i % 2) == 1;
`else
      exp_p = 1'b0;
`endif
      chk("gnt_port", 128'(gp[i]), 128'(exp_p));
      chk("gnt_cyc", 128'(gk[i]), 128'(1 + 10 * i));
    end
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    chk("idle_after", 128'(busy), 128'(0));

    @(negedge clk);
    s_req = 1'b1; s_we = 1'b0; s_addr = 28'h11;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) s_req = 1'b0;
      chk("l1_gnt", 128'(s_gnt), 128'(k == 1));
      chk("l1_done", 128'(s_done), 128'(k == 5));
      chk("l1_busy", 128'(busy1), 128'(k <= 5));
      if (k <= 4) chk("l1_addr", 128'(m1_addr), 128'(28'h10 + 28'(k - 1)));
      if (k == 5)
        chk("l1_rline", s_rline,
            128'h00000140_00000130_00000120_00000110);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_line_ctrl.md
# mem_line_ctrl

Line-transfer controller and arbiter between two cache-side requesters and the single-word main-memory bank port. Each accepted request moves one full cache line as a sequence of word accesses, with a configurable per-word access latency that models slow main memory. Read data is assembled into a line register, and completion is signalled with a one-cycle `done` pulse to the owning requester.

## Interface
- `ADDR_W`, 28: word-address width of the bank port.
- `WORDS_PER_LINE`, 4: words per line (power of 2, ≥2); `LINE_W = 32*WORDS_PER_LINE`.
- `ACCESS_LAT`, 2: cycles each word access occupies (≥1).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `r0_req` in 1: requester 0 line request; held until `r0_gnt`.
- `r0_we` in 1: 1 = line write, 0 = line read; valid with `r0_req`.
- `r0_addr` in `ADDR_W`: word address of the line; low log2(`WORDS_PER_LINE`) bits ignored.
- `r0_wline` in `LINE_W`: write line; word k in bits [32k+31:32k].
- `r0_gnt` out 1: one-cycle pulse, request accepted.
- `r0_done` out 1: one-cycle pulse, transfer complete.
- `r0_rline` out `LINE_W`: read line; valid from `r0_done` until the next read completes for port 0.
- `r1_req`, `r1_we`, `r1_addr`, `r1_wline`, `r1_gnt`, `r1_done`, `r1_rline`: identical, requester 1.
- `mem_addr` out `ADDR_W`: bank word address.
- `mem_we` out 1: bank write enable.
- `mem_wdata` out 32: bank write data.
- `mem_rdata` in 32: bank read data, combinational from `mem_addr`.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE:** if either request is high at the clock edge, choose a winner, latch its `we`, aligned base address, and write line, then move to ACCESS. The winner's `gnt` is high during the first ACCESS cycle.
- **ACCESS:** the word counter `wc` runs 0..`WORDS_PER_LINE`-1 and the latency counter `lc` runs 0..`ACCESS_LAT`-1.
  - `mem_addr` = base | `wc`, held stable for all `ACCESS_LAT` cycles of the word.
  - Write: `mem_wdata` = latched word `wc` for the whole word; `mem_we` = 1 only in the cycle where `lc` = `ACCESS_LAT`-1.
  - Read: `mem_rdata` is captured into line slot `wc` at the edge ending the `lc` = `ACCESS_LAT`-1 cycle.
  - After the last word the controller moves to DONE.
- **DONE:** `done` is high for one cycle on the owning port. For a read, that port's `rline` is updated with the assembled line no later than the `done` cycle. The next state is IDLE.
- Requests are sampled only in IDLE. A request raised in DONE waits, and a requester may drop `req` after `gnt`.
- Arbitration: a one-bit last-served pointer gives round-robin between the two requesters (see Configuration). A lone requester always wins.
- Address arithmetic: `wc` replaces the low offset bits of the base, so a line never crosses an alignment boundary and there is no carry into the upper bits.

## Timing
- Reset values: `r*_gnt` = `r*_done` = 0, `r*_rline` = 0, `mem_addr` = 0, `mem_we` = 0, `mem_wdata` = 0, `busy` = 0, state IDLE, pointer = 1 (so r0 wins the first tie).
- In IDLE and DONE, `mem_we` = 0 and `mem_addr` / `mem_wdata` = 0.
- Example, with `req` first seen high in cycle 0:
  - `gnt` in cycle 1.
  - ACCESS occupies cycles 1..`WORDS_PER_LINE`*`ACCESS_LAT` (defaults: 1..8).
  - `done` in cycle `WORDS_PER_LINE`*`ACCESS_LAT`+1 (defaults: 9).
  - IDLE in cycle 10; the earliest next `gnt` is cycle 11.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronously) and no `done` is issued. Words already written stay written, and `rline` is cleared.

## Configuration
- `MEM_LINE_CTRL_RR_EN` defined: round-robin arbitration. On simultaneous requests, the port not served last wins, and the pointer updates on every grant.
- `MEM_LINE_CTRL_RR_EN` undefined: fixed priority, r0 always wins a tie, and the pointer logic is removed.

## Test plan
- **Line read, port 0:** defaults, bank words 0..3 = 0x10, 0x20, 0x30, 0x40; `r0_req` with `we` = 0, `addr` = 0x0000002 → `r0_gnt` in cycle 1, `mem_addr` 0, 1, 2, 3 each held 2 cycles, `r0_done` in cycle 9, `r0_rline` = 0x00000040_00000030_00000020_00000010.
- **Line write, port 1:** `r1_addr` = 0x0000004, `r1_wline` = {0xD, 0xC, 0xB, 0xA} → `mem_we` single-cycle pulses in cycles 2, 4, 6, 8 with addr/data 4/0xA, 5/0xB, 6/0xC, 7/0xD. A following read of the same line returns the same value.
- **Simultaneous requests:** `r0_req` and `r1_req` held high continuously from reset → grants r0, r1, r0, r1 with macro defined; r0, r0, r0 without it. Each `gnt` comes 10 cycles after the previous one.
- **Latency 1:** `ACCESS_LAT` = 1 → one cycle per word, `done` in cycle 5, `busy` high in cycles 1..5.
- **Reset mid-write:** `rst` asserted in cycle 5 of a write to line 0x0000008 → `mem_we` and `busy` go to 0 immediately, no `done`; bank words 8–9 are updated and words 10–11 are unchanged.
